// File: rtl/spi_target.sv
// spi_target: SPI target (slave) endpoint for the far end of an SPI master.
//
// The SPI pins are oversampled in the clk_clk domain, so clk_clk must run at
// least 4x faster than SCLK. MOSI is deserialised into WORD_WIDTH-bit words,
// MSB first. A preloaded transmit word is serialised onto MISO. Fabric uses
// valid/ready handshakes on both sides.
//
// Ports:
//   clk_clk        system clock
//   reset_reset_n  asynchronous active-low reset
//   spi_sclk       SCLK from the master
//   spi_cs_n       chip select from the master, active low
//   spi_mosi       data from the master
//   spi_miso       data to the master
//   spi_miso_oe    MISO output enable; the tristate lives at top level
//   cpol, cpha     SPI mode; only taken while idle
//   tx_data        next word to send
//   tx_valid       tx_data valid
//   tx_ready       transmit holding register empty
//   rx_data        received word
//   rx_valid       rx_data valid, held until accepted
//   rx_ready       consumer accepts rx_data
//   rx_overrun     1-cycle pulse: a completed word was dropped
//   tx_underrun    1-cycle pulse: word load found the holding register empty
//   busy           high while a transfer is in progress
//
// Optional feature: define SPI_TARGET_RX_FIFO_EN to put a 4-entry FIFO
// between the deserialiser and rx_data/rx_valid.

module spi_target #(
  parameter int WORD_WIDTH = 8
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic [WORD_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [WORD_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  rx_overrun,
  output logic                  tx_underrun,
  output logic                  busy
);

  localparam int CNT_W = $clog2(WORD_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic r_sclkMeta, r_sclkSync, r_sclkPrev;
  logic r_csMeta, r_csSync, r_csPrev;
  logic r_mosiMeta, r_mosiSync;
  logic r_cpol, r_cpha;

  logic [CNT_W-1:0]      r_bitCnt;
  logic [WORD_WIDTH-2:0] r_rxShift;
  logic [WORD_WIDTH-1:0] r_txShift;
  logic [WORD_WIDTH-1:0] r_hold;
  logic                  r_holdFull;
  logic                  r_txUnderrun;
  logic                  r_rxOverrun;

  logic w_sclkEdge, w_leading, w_trailing;
  logic w_csFall, w_csRise;
  logic w_sample, w_shift, w_wordLoad, w_complete, w_overrun;
  logic [WORD_WIDTH-1:0] w_rxWord;

  // Two-flop synchronisers on all SPI inputs, plus one extra stage on SCLK
  // and CS_N so their edges can be detected.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_sclkMeta <= 1'b0;
      r_sclkSync <= 1'b0;
      r_sclkPrev <= 1'b0;
      r_csMeta   <= 1'b1;
      r_csSync   <= 1'b1;
      r_csPrev   <= 1'b1;
      r_mosiMeta <= 1'b0;
      r_mosiSync <= 1'b0;
    end else begin
      r_sclkMeta <= spi_sclk;
      r_sclkSync <= r_sclkMeta;
      r_sclkPrev <= r_sclkSync;
      r_csMeta   <= spi_cs_n;
      r_csSync   <= r_csMeta;
      r_csPrev   <= r_csSync;
      r_mosiMeta <= spi_mosi;
      r_mosiSync <= r_mosiMeta;
    end
  end

  // Leading edge moves SCLK away from its idle level; trailing returns to it.
  assign w_sclkEdge = r_sclkSync ^ r_sclkPrev;
  assign w_leading  = w_sclkEdge & (r_sclkSync != r_cpol);
  assign w_trailing = w_sclkEdge & (r_sclkSync == r_cpol);
  assign w_csFall   = r_csPrev & ~r_csSync;
  assign w_csRise   = ~r_csPrev & r_csSync;
  assign w_rxWord   = {r_rxShift, r_mosiSync};

  // The mode is frozen for the whole transfer once SHIFT is entered.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_cpol <= 1'b0;
      r_cpha <= 1'b0;
    end else if (r_state == IDLE) begin
      r_cpol <= cpol;
      r_cpha <= cpha;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A bit counter of zero marks the edge that would otherwise shift the
  // freshly loaded MSB away: the trailing edge right after a completion
  // (cpha=0) or the first leading edge of a word (cpha=1). Those edges
  // leave the shift register alone. Each completion reloads the next word.
  always_comb begin
    w_nextState = r_state;
    w_sample    = 1'b0;
    w_shift     = 1'b0;
    w_wordLoad  = 1'b0;
    w_complete  = 1'b0;
    spi_miso_oe = 1'b0;
    spi_miso    = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_csFall) begin
          w_nextState = SHIFT;
          w_wordLoad  = 1'b1;
        end
      end
      SHIFT: begin
        spi_miso_oe = 1'b1;
        spi_miso    = r_txShift[WORD_WIDTH-1];
        busy        = 1'b1;
        if (w_csRise) begin
          w_nextState = IDLE;
        end else if (w_leading) begin
          if (!r_cpha) w_sample = 1'b1;
          else if (r_bitCnt != '0) w_shift = 1'b1;
        end else if (w_trailing) begin
          if (r_cpha) w_sample = 1'b1;
          else if (r_bitCnt != '0) w_shift = 1'b1;
        end
        if (w_sample && (r_bitCnt == LAST_BIT)) begin
          w_complete = 1'b1;
          w_wordLoad = 1'b1;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Shift datapath and transmit holding register. A fabric write always
  // wins the holding register; a load in the same cycle sees it empty.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_bitCnt     <= '0;
      r_rxShift    <= '0;
      r_txShift    <= '0;
      r_hold       <= '0;
      r_holdFull   <= 1'b0;
      r_txUnderrun <= 1'b0;
    end else begin
      r_txUnderrun <= w_wordLoad & ~r_holdFull;
      if (w_wordLoad) begin
        r_bitCnt <= '0;
      end else if (w_sample) begin
        r_bitCnt <= r_bitCnt + CNT_W'(1);
      end
      if (w_sample) begin
        r_rxShift <= w_rxWord[WORD_WIDTH-2:0];
      end
      if (w_wordLoad) begin
        r_txShift <= r_holdFull ? r_hold : '0;
      end else if (w_shift) begin
        r_txShift <= {r_txShift[WORD_WIDTH-2:0], 1'b0};
      end
      if (tx_valid && !r_holdFull) begin
        r_hold     <= tx_data;
        r_holdFull <= 1'b1;
      end else if (w_wordLoad) begin
        r_holdFull <= 1'b0;
      end
    end
  end

`ifdef SPI_TARGET_RX_FIFO_EN
  logic [WORD_WIDTH-1:0] r_fifoMem [4];
  logic [1:0]            r_wrPtr, r_rdPtr;
  logic [2:0]            r_fifoCount;
  logic                  w_push, w_pop;

  // A full FIFO still accepts a push when the head is popped in that cycle.
  assign w_pop     = (r_fifoCount != 3'd0) && rx_ready;
  assign w_push    = w_complete && ((r_fifoCount != 3'd4) || w_pop);
  assign w_overrun = w_complete && !w_push;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < 4; i++) r_fifoMem[i] <= '0;
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_fifoCount <= '0;
    end else begin
      if (w_push) begin
        r_fifoMem[r_wrPtr] <= w_rxWord;
        r_wrPtr            <= r_wrPtr + 2'd1;
      end
      if (w_pop) r_rdPtr <= r_rdPtr + 2'd1;
      r_fifoCount <= r_fifoCount + {2'b00, w_push} - {2'b00, w_pop};
    end
  end

  assign rx_data  = r_fifoMem[r_rdPtr];
  assign rx_valid = (r_fifoCount != 3'd0);
`else
  logic [WORD_WIDTH-1:0] r_rxData;
  logic                  r_rxValid;

  // An unaccepted word blocks new ones; a word arriving then is dropped.
  assign w_overrun = w_complete && r_rxValid && !rx_ready;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_rxData  <= '0;
      r_rxValid <= 1'b0;
    end else if (w_complete && (!r_rxValid || rx_ready)) begin
      r_rxData  <= w_rxWord;
      r_rxValid <= 1'b1;
    end else if (r_rxValid && rx_ready) begin
      r_rxValid <= 1'b0;
    end
  end

  assign rx_data  = r_rxData;
  assign rx_valid = r_rxValid;
`endif

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_rxOverrun <= 1'b0;
    end else begin
      r_rxOverrun <= w_overrun;
    end
  end

  assign tx_ready    = ~r_holdFull;
  assign tx_underrun = r_txUnderrun;
  assign rx_overrun  = r_rxOverrun;

endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: bench for spi_target (WORD_WIDTH=8). It plays the SPI
// master and the fabric. A reference model tracks the holding register and
// the receive capacity, and pushes expected words into queues that a
// monitor process compares against DUT outputs.

module tb_spi_target;

  localparam int HP = 6;
`ifdef SPI_TARGET_RX_FIFO_EN
  localparam int RX_CAP = 4;
`else
  localparam int RX_CAP = 1;
`endif

  logic       clk_clk = 1'b0;
  logic       reset_reset_n;
  logic       spi_sclk, spi_cs_n, spi_mosi;
  logic       spi_miso, spi_miso_oe;
  logic       cpol, cpha;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic       rx_overrun, tx_underrun, busy;

  spi_target #(.WORD_WIDTH(8)) dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .spi_sclk     (spi_sclk),
    .spi_cs_n     (spi_cs_n),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .spi_miso_oe  (spi_miso_oe),
    .cpol         (cpol),
    .cpha         (cpha),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_overrun   (rx_overrun),
    .tx_underrun  (tx_underrun),
    .busy         (busy)
  );

  always #5 clk_clk = ~clk_clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] expRxQ[$];
  logic [7:0] expMisoQ[$];
  logic [7:0] gotMisoQ[$];
  int underrunSeen = 0, expUnderrun = 0;
  int overrunSeen = 0, expOverrun = 0;

  // Reference model: holding register contents and receive slots left.
  bit         modelFull = 1'b0;
  logic [7:0] modelHold = 8'h00;
  int         rxKeep = 1000;

  // Transfer plan for the master.
  logic [7:0] mosiWords [8];
  bit         refillOn [8];
  logic [7:0] refillWord [8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_clk);
      #2;
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT hands out a word.
  always @(negedge clk_clk) begin
    if (reset_reset_n) begin
      if (rx_valid && rx_ready) begin
        if (expRxQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL rx_unexpected actual=%0h expected=none", rx_data);
        end else begin
          checkOutput("rx_data", 32'(rx_data), 32'(expRxQ.pop_front()));
        end
      end
      if (tx_underrun) underrunSeen++;
      if (rx_overrun) overrunSeen++;
      while (gotMisoQ.size() > 0 && expMisoQ.size() > 0)
        checkOutput("miso_word", 32'(gotMisoQ.pop_front()), 32'(expMisoQ.pop_front()));
    end
  end

  task automatic modelLoad(output logic [7:0] w);
    if (modelFull) begin
      w = modelHold;
      modelFull = 1'b0;
    end else begin
      w = 8'h00;
      expUnderrun++;
    end
  endtask

  // One-cycle fabric write, issued only when the model says there is room.
  task automatic writeTx(input logic [7:0] w);
    checkOutput("tx_ready", 32'(tx_ready), 32'(!modelFull));
    if (!modelFull) begin
      tx_data  = w;
      tx_valid = 1'b1;
      tick(1);
      tx_valid = 1'b0;
      modelFull = 1'b1;
      modelHold = w;
    end else begin
      tick(1);
    end
  endtask

  task automatic clearPlan();
    for (int i = 0; i < 8; i++) begin
      refillOn[i] = 1'b0;
      refillWord[i] = 8'h00;
    end
  endtask

  task automatic setMode(input logic pol, input logic pha);
    cpol = pol;
    cpha = pha;
    spi_sclk = pol;
    tick(4);
  endtask

  // SPI master: nWords words, the last one cut to lastBits bits. abortMode
  // 0 ends with cs_n high, 1 ends with a reset pulse while cs_n is low.
  task automatic applyStimulus(input int nWords, input int lastBits, input int abortMode);
    logic [7:0] loaded, got;
    logic       nextBit;
    int         bits;
    bit         doRefill;
    spi_cs_n = 1'b0;
    modelLoad(loaded);
    if (!cpha) spi_mosi = mosiWords[0][7];
    tick(HP);
    for (int j = 0; j < nWords; j++) begin
      bits = (j == nWords - 1) ? lastBits : 8;
      got = 8'h00;
      if (bits == 8) begin
        expMisoQ.push_back(loaded);
        if (rxKeep > 0) begin
          expRxQ.push_back(mosiWords[j]);
          rxKeep--;
        end else begin
          expOverrun++;
        end
      end
      for (int b = 0; b < bits; b++) begin
        doRefill = (b == 2) && (j + 1 < nWords) && refillOn[j + 1];
        spi_sclk = ~cpol;
        if (!cpha) got = {got[6:0], spi_miso};
        else spi_mosi = mosiWords[j][7 - b];
        tick(HP);
        spi_sclk = cpol;
        if (cpha) begin
          got = {got[6:0], spi_miso};
        end else begin
          if (b < 7) nextBit = mosiWords[j][6 - b];
          else if (j + 1 < nWords) nextBit = mosiWords[j + 1][7];
          else nextBit = 1'b0;
          spi_mosi = nextBit;
        end
        if (doRefill) begin
          writeTx(refillWord[j + 1]);
          tick(HP - 1);
        end else begin
          tick(HP);
        end
      end
      if (bits == 8) begin
        gotMisoQ.push_back(got);
        modelLoad(loaded);
      end
    end
    if (abortMode == 0) begin
      checkOutput("busy_before_cs_rise", 32'(busy), 32'd1);
      spi_cs_n = 1'b1;
      tick(3);
      checkOutput("busy_after_cs_rise", 32'(busy), 32'd0);
      tick(6);
    end else begin
      reset_reset_n = 1'b0;
      #1;
      checkOutput("rst_miso", 32'(spi_miso), 32'd0);
      checkOutput("rst_miso_oe", 32'(spi_miso_oe), 32'd0);
      checkOutput("rst_rx_data", 32'(rx_data), 32'd0);
      checkOutput("rst_rx_valid", 32'(rx_valid), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_tx_ready", 32'(tx_ready), 32'd1);
      checkOutput("rst_underrun", 32'(tx_underrun), 32'd0);
      checkOutput("rst_overrun", 32'(rx_overrun), 32'd0);
      spi_cs_n = 1'b1;
      spi_sclk = cpol;
      tick(3);
      reset_reset_n = 1'b1;
      modelFull = 1'b0;
      tick(4);
    end
    checkOutput("underrun_count", 32'(underrunSeen), 32'(expUnderrun));
    checkOutput("overrun_count", 32'(overrunSeen), 32'(expOverrun));
  endtask

  initial begin
    int nW, lastB;
    reset_reset_n = 1'b0;
    spi_sclk = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    cpol = 1'b0;
    cpha = 1'b0;
    tx_data = 8'h00;
    tx_valid = 1'b0;
    rx_ready = 1'b1;
    clearPlan();
    #23;
    checkOutput("reset_miso_oe", 32'(spi_miso_oe), 32'd0);
    checkOutput("reset_rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("reset_rx_data", 32'(rx_data), 32'd0);
    checkOutput("reset_tx_ready", 32'(tx_ready), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    tick(1);
    reset_reset_n = 1'b1;
    tick(3);

    $display("[TB] mode 0 single word");
    setMode(1'b0, 1'b0);
    writeTx(8'hA5);
    mosiWords[0] = 8'h3C;
    applyStimulus(1, 8, 0);

    $display("[TB] mode 3 back-to-back with refill");
    setMode(1'b1, 1'b1);
    writeTx(8'hA5);
    mosiWords[0] = 8'h81;
    mosiWords[1] = 8'h7E;
    refillOn[1] = 1'b1;
    refillWord[1] = 8'h55;
    applyStimulus(2, 8, 0);
    clearPlan();

    $display("[TB] empty holding register");
    setMode(1'b0, 1'b1);
    mosiWords[0] = 8'h5A;
    applyStimulus(1, 8, 0);

    $display("[TB] receive overrun");
    setMode(1'b1, 1'b0);
    rx_ready = 1'b0;
    rxKeep = RX_CAP;
    for (int i = 0; i <= RX_CAP; i++) mosiWords[i] = 8'((i + 1) * 8'h11);
    applyStimulus(RX_CAP + 1, 8, 0);
    checkOutput("held_rx_valid", 32'(rx_valid), 32'd1);
    checkOutput("held_rx_data", 32'(rx_data), 32'h11);
    rx_ready = 1'b1;
    rxKeep = 1000;
    tick(RX_CAP + 3);

    $display("[TB] chip select abort then full word");
    setMode(1'b0, 1'b0);
    writeTx(8'h96);
    mosiWords[0] = 8'hFF;
    applyStimulus(1, 5, 0);
    checkOutput("abort_rx_valid", 32'(rx_valid), 32'd0);
    mosiWords[0] = 8'hC3;
    applyStimulus(1, 8, 0);

    $display("[TB] reset mid-word");
    setMode(1'b0, 1'b1);
    writeTx(8'h3E);
    mosiWords[0] = 8'h12;
    mosiWords[1] = 8'h34;
    applyStimulus(2, 4, 1);

    $display("[TB] randomized transfers");
    for (int t = 0; t < 12; t++) begin
      clearPlan();
      setMode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) writeTx(8'($urandom));
      nW = $urandom_range(1, 3);
      lastB = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
      for (int i = 0; i < nW; i++) begin
        mosiWords[i] = 8'($urandom);
        refillOn[i] = 1'($urandom_range(0, 1));
        refillWord[i] = 8'($urandom);
      end
      applyStimulus(nW, lastB, 0);
    end

    tick(10);
    checkOutput("rx_queue_drained", 32'(expRxQ.size()), 32'd0);
    checkOutput("miso_exp_drained", 32'(expMisoQ.size()), 32'd0);
    checkOutput("miso_got_drained", 32'(gotMisoQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
